pc_step_sequencer: RTL and testbench
====================================

PC_STEP_SEQUENCER -- requirements
Module: pc_step_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on pc_ack (legal values 2..4).
REQ-002 Parameter SETTLE, default 3: clock cycles from synchronized pc_ack rise to pc_data capture (legal values 1..15).
REQ-003 Parameter TIMEOUT, default 255: max cycles to wait on any pc_ack edge (legal values 1..255).
REQ-004 Parameter FETCH_INC, default 2'b01: increment code issued for a fetch request.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_fetch  in  1  level request for a sequential PC step.
REQ-008 req_skip  in  1  level request for a skip/jump step.
REQ-009 skip_inc  in  2  increment code for skip; sampled at grant.
REQ-010 pc_ack  in  1  ack from the async PC stage (handshake request-acknowledge); unsynchronized.
REQ-011 pc_data  in  8  PC value from the async PC pipeline.
REQ-012 pc_inc  out  2  increment code driven to the PC; 2'b00 = no step.
REQ-013 pc_ack_out  out  1  consumer acknowledge to the PC (its ack_in).
REQ-014 pc_value  out  8  last captured PC value, registered.
REQ-015 gnt_fetch, gnt_skip  out  1 each  one-cycle pulse when the step for that requester completes.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err_timeout  out  1  sticky flag; cleared only by rst.

Function
REQ-018 pc_ack SHALL pass through a SYNC_STAGES flop chain; only the synchronized ack (sack) is used internally.
REQ-019 FSM states: IDLE, ISSUE, SETTLE_W, RELEASE, DONE.
REQ-020 IDLE: if any request is pending, select a winner, latch its code (FETCH_INC or skip_inc), then go to ISSUE next cycle; otherwise stay.
REQ-021 Arbitration: round-robin; on simultaneous requests, grant the requester not served last; after reset, fetch wins the first tie.
REQ-022 A latched skip code of 2'b00 SHALL complete as a no-op: straight to DONE, pc_inc untouched, pc_value unchanged, gnt_skip pulsed.
REQ-023 ISSUE: pc_inc = latched code; wait for sack=1, then go to SETTLE_W and clear the settle counter.
REQ-024 SETTLE_W: count SETTLE cycles; on the terminal count, capture pc_data into pc_value, assert pc_ack_out=1, drive pc_inc=2'b00, then go to RELEASE.
REQ-025 RELEASE: hold pc_ack_out=1 until sack=0, then deassert pc_ack_out and go to DONE.
REQ-026 DONE: pulse the winner's gnt for exactly one cycle, update the round-robin pointer, then go to IDLE; a new grant SHALL NOT start earlier than the cycle after DONE.
REQ-027 Request drops after the grant SHALL be ignored; the step completes.
REQ-028 Timeout: an 8-bit counter clears on entering ISSUE or RELEASE and increments every cycle in those states. If it reaches TIMEOUT:
- set err_timeout;
- drive pc_inc=00 and pc_ack_out=0;
- go to IDLE with no gnt pulse;
- leave the round-robin pointer unchanged.
REQ-029 sack already high on entering ISSUE (stale ack) SHALL NOT be accepted; ISSUE accepts only a 0->1 transition of sack seen after entry.
REQ-030 pc_inc, pc_ack_out, gnt_*, busy SHALL be registered outputs.

Reset
REQ-031 On rst (async assert) the following SHALL take effect immediately, from any state including mid-handshake:
- state=IDLE;
- pc_inc=00, pc_ack_out=0, pc_value=8'h00;
- gnt_*=0, busy=0, err_timeout=0;
- sync chain and counters cleared;
- round-robin favours fetch.
REQ-032 Deassertion SHALL be synchronous to clk; the first request may be granted on the first edge after release.

Verification
REQ-033 Single fetch, PC model acks after 4 cycles, pc_data=8'h57 -> pc_inc=01 until sack; pc_value=8'h57; gnt_fetch pulses once; busy low after DONE.
REQ-034 req_fetch and req_skip together, skip_inc=10, held for 3 steps -> grant order fetch, skip, fetch; pc_inc sequence 01,10,01.
REQ-035 PC model never acks, TIMEOUT=20 -> err_timeout set 20 cycles after ISSUE entry; pc_inc=00; no gnt; next request still serviced.
REQ-036 rst asserted during RELEASE with pc_ack_out=1 -> same cycle pc_ack_out=0, pc_inc=00, pc_value=00, busy=0.
REQ-037 Skip with skip_inc=00 -> gnt_skip pulses within 3 cycles; pc_inc stays 00; pc_value unchanged.
REQ-038 pc_ack stuck high at grant -> ISSUE waits; the step completes only after pc_ack falls and rises again.

Source files
------------

// File: rtl/pc_step_sequencer_if.sv
// Request/grant and asynchronous-PC handshake bundle of the step sequencer.
// slave is the sequencer side; master is the requester/PC-model side.
interface pc_step_sequencer_if;
    logic       req_fetch;
    logic       req_skip;
    logic [1:0] skip_inc;
    logic       pc_ack;
    logic [7:0] pc_data;
    logic [1:0] pc_inc;
    logic       pc_ack_out;
    logic [7:0] pc_value;
    logic       gnt_fetch;
    logic       gnt_skip;
    logic       busy;
    logic       err_timeout;

    modport slave (
        input  req_fetch, req_skip, skip_inc, pc_ack, pc_data,
        output pc_inc, pc_ack_out, pc_value, gnt_fetch, gnt_skip, busy, err_timeout
    );

    modport master (
        output req_fetch, req_skip, skip_inc, pc_ack, pc_data,
        input  pc_inc, pc_ack_out, pc_value, gnt_fetch, gnt_skip, busy, err_timeout
    );
endinterface

// File: rtl/pc_step_sequencer.sv
// Round-robin fetch/skip arbiter driving a 4-phase handshake to an async PC stage.
// Latency: grant 1 cycle after request; step = ack wait + SYNC_STAGES + SETTLE + release + DONE.
// Backpressure: requests are level-held; one step in flight, ack waits bounded by TIMEOUT.
module pc_step_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 3,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [1:0]  FETCH_INC   = 2'b01
) (
    input logic                clk,
    input logic                rst,
    pc_step_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE_W,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sack;
    logic                   seen_low_q, seen_low_d;
    logic [7:0]             to_cnt_q, to_cnt_d;
    logic [3:0]             settle_cnt_q, settle_cnt_d;
    logic [1:0]             code_q, code_d;
    logic                   win_skip_q, win_skip_d;
    logic                   last_skip_q, last_skip_d;
    logic [1:0]             pc_inc_q, pc_inc_d;
    logic                   pc_ack_out_q, pc_ack_out_d;
    logic [7:0]             pc_value_q, pc_value_d;
    logic                   gnt_fetch_q, gnt_fetch_d;
    logic                   gnt_skip_q, gnt_skip_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   pick_skip;
    logic [1:0]             sel_code;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pc_ack};
        sack   = sync_q[SYNC_STAGES-1];
    end

    // Skip wins when it is alone, or on a tie when fetch was served last.
    always_comb begin
        pick_skip = bus.req_skip && (!bus.req_fetch || !last_skip_q);
        sel_code  = pick_skip ? bus.skip_inc : FETCH_INC;
    end

    always_comb begin
        state_d      = state_q;
        seen_low_d   = seen_low_q;
        to_cnt_d     = to_cnt_q;
        settle_cnt_d = settle_cnt_q;
        code_d       = code_q;
        win_skip_d   = win_skip_q;
        last_skip_d  = last_skip_q;
        pc_inc_d     = pc_inc_q;
        pc_ack_out_d = pc_ack_out_q;
        pc_value_d   = pc_value_q;
        gnt_fetch_d  = 1'b0;
        gnt_skip_d   = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_fetch || bus.req_skip) begin
                    win_skip_d = pick_skip;
                    code_d     = sel_code;
                    if (sel_code == 2'b00) begin
                        // A zero code has nothing to step: complete without touching the PC.
                        state_d     = S_DONE;
                        gnt_skip_d  = pick_skip;
                        gnt_fetch_d = !pick_skip;
                    end else begin
                        state_d    = S_ISSUE;
                        pc_inc_d   = sel_code;
                        to_cnt_d   = 8'd0;
                        seen_low_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                to_cnt_d = to_cnt_q + 8'd1;
                if (!sack) seen_low_d = 1'b1;
                // Only a rise observed after entry counts; a stale high ack is ignored.
                if (sack && seen_low_q) begin
                    state_d      = S_SETTLE_W;
                    settle_cnt_d = 4'd0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d      = S_IDLE;
                    err_d        = 1'b1;
                    pc_inc_d     = 2'b00;
                    pc_ack_out_d = 1'b0;
                end
            end
            S_SETTLE_W: begin
                if (settle_cnt_q == SET_LAST) begin
                    pc_value_d   = bus.pc_data;
                    pc_ack_out_d = 1'b1;
                    pc_inc_d     = 2'b00;
                    to_cnt_d     = 8'd0;
                    state_d      = S_RELEASE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            S_RELEASE: begin
                to_cnt_d = to_cnt_q + 8'd1;
                if (!sack) begin
                    pc_ack_out_d = 1'b0;
                    state_d      = S_DONE;
                    gnt_skip_d   = win_skip_q;
                    gnt_fetch_d  = !win_skip_q;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d      = S_IDLE;
                    err_d        = 1'b1;
                    pc_inc_d     = 2'b00;
                    pc_ack_out_d = 1'b0;
                end
            end
            S_DONE: begin
                last_skip_d = win_skip_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            seen_low_q   <= 1'b0;
            to_cnt_q     <= 8'd0;
            settle_cnt_q <= 4'd0;
            code_q       <= 2'b00;
            win_skip_q   <= 1'b0;
            last_skip_q  <= 1'b1;
            pc_inc_q     <= 2'b00;
            pc_ack_out_q <= 1'b0;
            pc_value_q   <= 8'h00;
            gnt_fetch_q  <= 1'b0;
            gnt_skip_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            seen_low_q   <= seen_low_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            code_q       <= code_d;
            win_skip_q   <= win_skip_d;
            last_skip_q  <= last_skip_d;
            pc_inc_q     <= pc_inc_d;
            pc_ack_out_q <= pc_ack_out_d;
            pc_value_q   <= pc_value_d;
            gnt_fetch_q  <= gnt_fetch_d;
            gnt_skip_q   <= gnt_skip_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign bus.pc_inc      = pc_inc_q;
    assign bus.pc_ack_out  = pc_ack_out_q;
    assign bus.pc_value    = pc_value_q;
    assign bus.gnt_fetch   = gnt_fetch_q;
    assign bus.gnt_skip    = gnt_skip_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_pc_step_sequencer.sv
// Directed bench for pc_step_sequencer with a behavioural async-PC model.
module tb_pc_step_sequencer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   model_mode;   // 0 = auto-ack, 1 = never ack, 2 = pc_ack follows man_ack
    int   ack_delay;
    int   model_cnt;
    logic man_ack;

    pc_step_sequencer_if pcif();

    pc_step_sequencer #(
        .SYNC_STAGES(2),
        .SETTLE     (3),
        .TIMEOUT    (20),
        .FETCH_INC  (2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(pcif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        pcif.pc_ack = 1'b0;
        model_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (model_mode == 1) pcif.pc_ack = 1'b0;
            else if (model_mode == 2) pcif.pc_ack = man_ack;
            else if (!pcif.pc_ack && pcif.pc_inc != 2'b00) begin
                model_cnt++;
                if (model_cnt >= ack_delay) begin
                    pcif.pc_ack = 1'b1;
                    model_cnt   = 0;
                end
            end else if (pcif.pc_ack && pcif.pc_ack_out) pcif.pc_ack = 1'b0;
            else if (!pcif.pc_ack) model_cnt = 0;
        end
    end

    task automatic wait_gnt(input int limit, output logic gf, output logic gs,
                            output int cyc, output logic [1:0] inc);
        gf = 1'b0; gs = 1'b0; cyc = 0; inc = 2'b00;
        while (!gf && !gs && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (pcif.pc_inc != 2'b00) inc = pcif.pc_inc;
            gf = pcif.gnt_fetch;
            gs = pcif.gnt_skip;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (pcif.pc_inc !== 2'b00) begin tests_failed++; $display("FAIL reset_pc_inc: got %b expected 00", pcif.pc_inc); end
        tests_run++; if (pcif.pc_ack_out !== 1'b0) begin tests_failed++; $display("FAIL reset_ack_out: got %b expected 0", pcif.pc_ack_out); end
        tests_run++; if (pcif.pc_value !== 8'h00) begin tests_failed++; $display("FAIL reset_pc_value: got %h expected 00", pcif.pc_value); end
        tests_run++; if ({pcif.gnt_fetch, pcif.gnt_skip} !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 00", {pcif.gnt_fetch, pcif.gnt_skip}); end
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", pcif.busy); end
        tests_run++; if (pcif.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", pcif.err_timeout); end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic gf, gs; int cyc; logic [1:0] inc;
        model_mode = 0; ack_delay = 4; pcif.pc_data = 8'h57;
        pcif.req_fetch = 1'b1;
        @(negedge clk);
        tests_run++; if (pcif.pc_inc !== 2'b01) begin tests_failed++; $display("FAIL fetch_issue_inc: got %b expected 01", pcif.pc_inc); end
        tests_run++; if (pcif.busy !== 1'b1) begin tests_failed++; $display("FAIL fetch_busy: got %b expected 1", pcif.busy); end
        pcif.req_fetch = 1'b0;
        wait_gnt(60, gf, gs, cyc, inc);
        tests_run++; if ({gf, gs} !== 2'b10) begin tests_failed++; $display("FAIL fetch_gnt: got %b expected 10 after %0d cycles", {gf, gs}, cyc); end
        tests_run++; if (pcif.pc_value !== 8'h57) begin tests_failed++; $display("FAIL fetch_pc_value: got %h expected 57", pcif.pc_value); end
        @(negedge clk);
        tests_run++; if (pcif.gnt_fetch !== 1'b0) begin tests_failed++; $display("FAIL fetch_gnt_pulse: got %b expected 0", pcif.gnt_fetch); end
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL fetch_busy_idle: got %b expected 0", pcif.busy); end
        repeat (5) @(negedge clk);
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL fetch_no_regrant: got busy %b expected 0", pcif.busy); end
    endtask

    task automatic test_skip_noop();
        logic gf, gs; int cyc; logic [1:0] inc;
        pcif.pc_data = 8'hEE; pcif.skip_inc = 2'b00; pcif.req_skip = 1'b1;
        wait_gnt(3, gf, gs, cyc, inc);
        pcif.req_skip = 1'b0;
        tests_run++; if ({gf, gs} !== 2'b01) begin tests_failed++; $display("FAIL noop_gnt: got %b expected 01 within 3 cycles", {gf, gs}); end
        tests_run++; if (inc !== 2'b00) begin tests_failed++; $display("FAIL noop_pc_inc: got %b expected 00", inc); end
        tests_run++; if (pcif.pc_value !== 8'h57) begin tests_failed++; $display("FAIL noop_pc_value: got %h expected 57", pcif.pc_value); end
        repeat (3) @(negedge clk);
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL noop_busy_idle: got %b expected 0", pcif.busy); end
    endtask

    task automatic test_round_robin();
        logic gf, gs; int cyc; logic [1:0] inc;
        logic [1:0] exp_g, exp_inc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_mode = 0; ack_delay = 3; pcif.skip_inc = 2'b10;
        pcif.req_fetch = 1'b1; pcif.req_skip = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(80, gf, gs, cyc, inc);
            if (i == 2) begin pcif.req_fetch = 1'b0; pcif.req_skip = 1'b0; end
            exp_g   = (i == 1) ? 2'b01 : 2'b10;
            exp_inc = (i == 1) ? 2'b10 : 2'b01;
            tests_run++; if ({gf, gs} !== exp_g) begin tests_failed++; $display("FAIL rr_order step %0d: got %b expected %b", i, {gf, gs}, exp_g); end
            tests_run++; if (inc !== exp_inc) begin tests_failed++; $display("FAIL rr_inc step %0d: got %b expected %b", i, inc, exp_inc); end
        end
        repeat (4) @(negedge clk);
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL rr_idle: got busy %b expected 0", pcif.busy); end
    endtask

    task automatic test_timeout();
        logic gf, gs, gseen; int cyc; logic [1:0] inc;
        model_mode = 1; pcif.req_fetch = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (pcif.pc_inc == 2'b00 && cyc < 10);
        pcif.req_fetch = 1'b0;
        tests_run++; if (pcif.pc_inc !== 2'b01) begin tests_failed++; $display("FAIL to_issue: got %b expected 01", pcif.pc_inc); end
        cyc = 0; gseen = 1'b0;
        while (pcif.err_timeout !== 1'b1 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (pcif.gnt_fetch || pcif.gnt_skip) gseen = 1'b1;
        end
        tests_run++; if (cyc != 20) begin tests_failed++; $display("FAIL to_latency: got %0d cycles expected 20", cyc); end
        tests_run++; if (pcif.err_timeout !== 1'b1) begin tests_failed++; $display("FAIL to_err: got %b expected 1", pcif.err_timeout); end
        tests_run++; if (pcif.pc_inc !== 2'b00) begin tests_failed++; $display("FAIL to_pc_inc: got %b expected 00", pcif.pc_inc); end
        tests_run++; if (pcif.pc_ack_out !== 1'b0) begin tests_failed++; $display("FAIL to_ack_out: got %b expected 0", pcif.pc_ack_out); end
        tests_run++; if (gseen !== 1'b0) begin tests_failed++; $display("FAIL to_no_gnt: got %b expected 0", gseen); end
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b expected 0", pcif.busy); end
        model_mode = 0; pcif.skip_inc = 2'b11; pcif.req_skip = 1'b1;
        wait_gnt(60, gf, gs, cyc, inc);
        pcif.req_skip = 1'b0;
        tests_run++; if ({gf, gs} !== 2'b01) begin tests_failed++; $display("FAIL to_next_gnt: got %b expected 01", {gf, gs}); end
        tests_run++; if (inc !== 2'b11) begin tests_failed++; $display("FAIL to_next_inc: got %b expected 11", inc); end
        tests_run++; if (pcif.err_timeout !== 1'b1) begin tests_failed++; $display("FAIL to_err_sticky: got %b expected 1", pcif.err_timeout); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_release();
        int cyc;
        model_mode = 2; man_ack = 1'b0; pcif.pc_data = 8'hA5; pcif.req_fetch = 1'b1;
        @(negedge clk);
        pcif.req_fetch = 1'b0; man_ack = 1'b1;
        cyc = 0;
        while (pcif.pc_ack_out !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        tests_run++; if (pcif.pc_ack_out !== 1'b1) begin tests_failed++; $display("FAIL rst_rel_reached: got ack_out %b expected 1", pcif.pc_ack_out); end
        tests_run++; if (pcif.pc_value !== 8'hA5) begin tests_failed++; $display("FAIL rst_rel_value: got %h expected a5", pcif.pc_value); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (pcif.pc_ack_out !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ack_out: got %b expected 0", pcif.pc_ack_out); end
        tests_run++; if (pcif.pc_inc !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_pc_inc: got %b expected 00", pcif.pc_inc); end
        tests_run++; if (pcif.pc_value !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_pc_value: got %h expected 00", pcif.pc_value); end
        tests_run++; if (pcif.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", pcif.busy); end
        tests_run++; if (pcif.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_err: got %b expected 0", pcif.err_timeout); end
        man_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stale_ack();
        logic gf, gs, early; int cyc; logic [1:0] inc;
        model_mode = 2; man_ack = 1'b1;
        repeat (4) @(negedge clk);
        pcif.pc_data = 8'h9C; pcif.req_fetch = 1'b1;
        @(negedge clk);
        pcif.req_fetch = 1'b0;
        tests_run++; if (pcif.busy !== 1'b1) begin tests_failed++; $display("FAIL stale_issue: got busy %b expected 1", pcif.busy); end
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (pcif.pc_ack_out !== 1'b0 || pcif.pc_value !== 8'h00) early = 1'b1;
        end
        tests_run++; if (early !== 1'b0) begin tests_failed++; $display("FAIL stale_ignored: got %b expected 0", early); end
        tests_run++; if (pcif.pc_inc !== 2'b01) begin tests_failed++; $display("FAIL stale_still_issue: got %b expected 01", pcif.pc_inc); end
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        man_ack = 1'b1;
        cyc = 0;
        while (pcif.pc_ack_out !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        man_ack = 1'b0;
        wait_gnt(20, gf, gs, cyc, inc);
        tests_run++; if ({gf, gs} !== 2'b10) begin tests_failed++; $display("FAIL stale_gnt: got %b expected 10", {gf, gs}); end
        tests_run++; if (pcif.pc_value !== 8'h9C) begin tests_failed++; $display("FAIL stale_value: got %h expected 9c", pcif.pc_value); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        model_mode = 1; ack_delay = 4; man_ack = 1'b0;
        rst = 1'b1;
        pcif.req_fetch = 1'b0; pcif.req_skip = 1'b0;
        pcif.skip_inc = 2'b00; pcif.pc_data = 8'h00;
        test_reset();
        test_single_fetch();
        test_skip_noop();
        test_round_robin();
        test_timeout();
        test_reset_release();
        test_stale_ack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
